// File: rtl/sdram_host_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sdram_host_pkg: shared types for the SDRAM host request queue        |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package sdram_host_pkg;

  localparam int HOST_ADDR_W = 24;
  localparam int HOST_DATA_W = 16;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic                   we;
    logic [HOST_ADDR_W-1:0] addr;
    logic [HOST_DATA_W-1:0] wdata;
  } req_t;

endpackage
`default_nettype wire

// File: rtl/sdram_req_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sdram_req_fifo: synchronous request FIFO with first-word fall-through|
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module sdram_req_fifo
  import sdram_host_pkg::*;
#(
  parameter int  DEPTH   = 4,
  parameter type ENTRY_T = req_t
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  ENTRY_T                 push_data,
  input  logic                   pop,
  output ENTRY_T                 head,
  output logic [$clog2(DEPTH):0] level,
  output logic                   full,
  output logic                   empty
);

  localparam int PTR_W = $clog2(DEPTH);

  ENTRY_T           mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (level == ($clog2(DEPTH)+1)'(DEPTH));
  assign empty   = (level == '0);
  assign head    = mem[rd_ptr];
  assign do_pop  = pop && !empty;
  // A simultaneous pop frees the slot, so a push into a full FIFO is legal then
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/sdram_host_queue.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sdram_host_queue: request FIFO, issue sequencer and response slot    |
// | feeding the SDRAM controller host port. Optional SDRAM_HOST_QUEUE_STATS_EN
// | adds saturating write/read/drop counters. Revision: 1.0             |
// +----------------------------------------------------------------------+
module sdram_host_queue
  import sdram_host_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter int ADDR_W    = HOST_ADDR_W,
  parameter int DATA_W    = HOST_DATA_W,
  parameter int BUSY_WAIT = 15
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_we,
  input  logic [ADDR_W-1:0]      req_addr,
  input  logic [DATA_W-1:0]      req_wdata,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [DATA_W-1:0]      rsp_data,
  output logic [ADDR_W-1:0]      ctl_wr_addr,
  output logic [DATA_W-1:0]      ctl_wr_data,
  output logic                   ctl_wr_en,
  output logic                   ctl_rd_en,
  input  logic                   ctl_busy,
  input  logic [DATA_W-1:0]      ctl_rd_data,
  input  logic                   ctl_rd_ready,
  output logic [$clog2(DEPTH):0] q_level
`ifdef SDRAM_HOST_QUEUE_STATS_EN
  ,
  output logic [15:0]            stat_wr_cnt,
  output logic [15:0]            stat_rd_cnt,
  output logic [7:0]             stat_drop_cnt
`endif
);

  localparam int CNT_W = $clog2(BUSY_WAIT + 1);

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } entry_t;

  state_t           state;
  state_t           next_state;
  entry_t           in_req;
  entry_t           head;
  entry_t           cmd;
  logic             fifo_full;
  logic             fifo_empty;
  logic             pop;
  logic             capture;
  logic             wr_en_d;
  logic             rd_en_d;
  logic             captured;
  logic [CNT_W-1:0] wait_cnt;

  assign in_req      = {req_we, req_addr, req_wdata};
  assign req_ready   = !fifo_full;
  assign ctl_wr_addr = cmd.addr;
  assign ctl_wr_data = cmd.wdata;

  sdram_req_fifo #(
    .DEPTH   (DEPTH),
    .ENTRY_T (entry_t)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (req_valid && req_ready),
    .push_data (in_req),
    .pop       (pop),
    .head      (head),
    .level     (q_level),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      // Reads wait for an empty response slot; nothing overtakes the head
      IDLE:      if (!fifo_empty && !ctl_busy && (head.we || !rsp_valid))
                   next_state = ISSUE;
      ISSUE:     if (ctl_busy)
                   next_state = WAIT_DONE;
                 else if (wait_cnt == CNT_W'(BUSY_WAIT - 1))
                   next_state = IDLE;
      WAIT_DONE: if (!ctl_busy && (cmd.we || captured || ctl_rd_ready))
                   next_state = IDLE;
      default:   next_state = IDLE;
    endcase
  end

  always_comb begin
    pop     = (state == IDLE) && (next_state == ISSUE);
    capture = (state == WAIT_DONE) && !cmd.we && ctl_rd_ready && !captured;
    wr_en_d = (next_state == ISSUE) && (pop ? head.we : cmd.we);
    rd_en_d = (next_state == ISSUE) && !(pop ? head.we : cmd.we);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cmd       <= '0;
      ctl_wr_en <= 1'b0;
      ctl_rd_en <= 1'b0;
      wait_cnt  <= '0;
      captured  <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
    end else begin
      ctl_wr_en <= wr_en_d;
      ctl_rd_en <= rd_en_d;
      if (pop) cmd <= head;
      if ((state == ISSUE) && !ctl_busy) wait_cnt <= wait_cnt + 1'b1;
      else                               wait_cnt <= '0;
      if (capture)                 captured <= 1'b1;
      else if (state != WAIT_DONE) captured <= 1'b0;
      // A capture wins over a same-cycle consume so fresh data is never lost
      if (capture) begin
        rsp_valid <= 1'b1;
        rsp_data  <= ctl_rd_data;
      end else if (rsp_valid && rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end
  end

`ifdef SDRAM_HOST_QUEUE_STATS_EN
  logic wr_done;
  logic timeout;

  assign wr_done = (state == WAIT_DONE) && (next_state == IDLE) && cmd.we;
  assign timeout = (state == ISSUE) && (next_state == IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_wr_cnt   <= '0;
      stat_rd_cnt   <= '0;
      stat_drop_cnt <= '0;
    end else begin
      if (wr_done && (stat_wr_cnt != '1))   stat_wr_cnt   <= stat_wr_cnt + 1'b1;
      if (capture && (stat_rd_cnt != '1))   stat_rd_cnt   <= stat_rd_cnt + 1'b1;
      if (timeout && (stat_drop_cnt != '1)) stat_drop_cnt <= stat_drop_cnt + 1'b1;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_sdram_host_queue.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_sdram_host_queue: scoreboard bench with a simple controller model |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_sdram_host_queue;

  typedef struct packed {
    logic        we;
    logic [23:0] addr;
    logic [15:0] wdata;
  } cmd_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we;
  logic [23:0] req_addr;
  logic [15:0] req_wdata;
  logic        rsp_valid, rsp_ready;
  logic [15:0] rsp_data;
  logic [23:0] ctl_wr_addr;
  logic [15:0] ctl_wr_data;
  logic        ctl_wr_en, ctl_rd_en, ctl_busy, ctl_rd_ready;
  logic [15:0] ctl_rd_data;
  logic [2:0]  q_level;
`ifdef SDRAM_HOST_QUEUE_STATS_EN
  logic [15:0] stat_wr_cnt, stat_rd_cnt;
  logic [7:0]  stat_drop_cnt;
`endif

  int   n_checks = 0;
  int   n_fail   = 0;
  int   issued   = 0;
  cmd_t exp_cmd[$];
  logic [15:0] exp_rsp[$];

  logic force_busy = 1'b0;
  logic never_busy = 1'b0;
  int   busy_len   = 3;

  sdram_host_queue dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_data     (rsp_data),
    .ctl_wr_addr  (ctl_wr_addr),
    .ctl_wr_data  (ctl_wr_data),
    .ctl_wr_en    (ctl_wr_en),
    .ctl_rd_en    (ctl_rd_en),
    .ctl_busy     (ctl_busy),
    .ctl_rd_data  (ctl_rd_data),
    .ctl_rd_ready (ctl_rd_ready),
    .q_level      (q_level)
`ifdef SDRAM_HOST_QUEUE_STATS_EN
    ,
    .stat_wr_cnt   (stat_wr_cnt),
    .stat_rd_cnt   (stat_rd_cnt),
    .stat_drop_cnt (stat_drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] model_data(input logic [23:0] a);
    return (a == 24'hbedfed) ? 16'hbbbb : (a[15:0] ^ 16'h1234);
  endfunction

  // Controller model: busy one cycle after an enable, held busy_len cycles,
  // read data presented with rd_ready on the cycle busy falls.
  initial begin : ctl_model
    int          cnt;
    logic        is_rd;
    logic [23:0] a;
    cnt = 0; is_rd = 1'b0; a = '0;
    ctl_busy = 1'b0; ctl_rd_ready = 1'b0; ctl_rd_data = '0;
    forever begin
      @(posedge clk); #1;
      ctl_rd_ready = 1'b0;
      if (rst) begin
        cnt = 0; ctl_busy = 1'b0;
      end else if (force_busy) begin
        ctl_busy = 1'b1;
      end else if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          ctl_busy = 1'b0;
          if (is_rd) begin
            ctl_rd_ready = 1'b1;
            ctl_rd_data  = model_data(a);
          end
        end
      end else if (!never_busy && (ctl_wr_en || ctl_rd_en)) begin
        ctl_busy = 1'b1; cnt = busy_len; is_rd = ctl_rd_en; a = ctl_wr_addr;
      end else begin
        ctl_busy = 1'b0;
      end
    end
  end

  // Monitor: pops expected commands on each enable rise, responses on handshake
  initial begin : monitor
    logic prev_en;
    cmd_t cur;
    prev_en = 1'b0;
    cur = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_en = 1'b0;
      end else begin
        if (ctl_wr_en && ctl_rd_en) chk("both_enables", 1, 0);
        if ((ctl_wr_en || ctl_rd_en) && !prev_en) begin
          issued++;
          if (exp_cmd.size() == 0) begin
            chk("unexpected_cmd", {ctl_wr_en, ctl_wr_addr, ctl_wr_data}, 0);
          end else begin
            cur = exp_cmd.pop_front();
            chk("cmd", {ctl_wr_en, ctl_wr_addr, ctl_wr_data}, cur);
            chk("cmd_rd_en", ctl_rd_en, !cur.we);
          end
        end else if (ctl_wr_en || ctl_rd_en) begin
          chk("cmd_stable", {ctl_wr_en, ctl_wr_addr, ctl_wr_data}, cur);
        end
        prev_en = ctl_wr_en || ctl_rd_en;
        if (rsp_valid && rsp_ready) begin
          if (exp_rsp.size() == 0) chk("unexpected_rsp", rsp_data, 0);
          else                     chk("rsp_data", rsp_data, exp_rsp.pop_front());
        end
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic push_req(input logic we, input logic [23:0] a, input logic [15:0] d);
    int n;
    exp_cmd.push_back({we, a, d});
    req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d;
    n = 0;
    while (!req_ready && n < 200) begin cyc(1); n++; end
    if (n >= 200) chk("push_timeout", 0, 1);
    cyc(1);
    req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (!(q_level == 0 && !ctl_wr_en && !ctl_rd_en && !ctl_busy && exp_cmd.size() == 0)
           && n < 500) begin
      cyc(1); n++;
    end
    if (n >= 500) chk("idle_timeout", 0, 1);
    cyc(3);
  endtask

  task automatic wait_en();
    int n;
    n = 0;
    while (!(ctl_wr_en || ctl_rd_en) && n < 100) begin cyc(1); n++; end
    if (n >= 100) chk("enable_timeout", 0, 1);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int n;
    int base;
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    rsp_ready = 1'b1;
    cyc(3);
    chk("rst_req_ready", req_ready, 1);
    chk("rst_q_level", q_level, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_enables", {ctl_wr_en, ctl_rd_en}, 0);
    chk("rst_ctl_addr_data", {ctl_wr_addr, ctl_wr_data}, 0);
    rst = 1'b0;
    cyc(2);

    // Single write, busy held 20 cycles
    busy_len = 20;
    push_req(1'b1, 24'hfedbed, 16'd3333);
    chk("wr_latency_early", ctl_wr_en, 0);
    chk("wr_q_level", q_level, 1);
    cyc(1);
    chk("wr_latency", ctl_wr_en, 1);
    chk("wr_addr", ctl_wr_addr, 24'hfedbed);
    chk("wr_data", ctl_wr_data, 16'd3333);
    cyc(1);
    chk("wr_drop_on_busy", ctl_wr_en, 0);
    chk("wr_addr_hold", ctl_wr_addr, 24'hfedbed);
    wait_idle();
    busy_len = 3;

    // Read returning 16'hbbbb, held until consumed
    rsp_ready = 1'b0;
    exp_rsp.push_back(16'hbbbb);
    push_req(1'b0, 24'hbedfed, 16'h0000);
    n = 0;
    while (!rsp_valid && n < 100) begin cyc(1); n++; end
    chk("rd_rsp_valid", rsp_valid, 1);
    repeat (3) begin
      cyc(1);
      chk("rd_rsp_hold", {rsp_valid, rsp_data}, {1'b1, 16'hbbbb});
    end
    rsp_ready = 1'b1;
    cyc(1);
    chk("rd_rsp_consumed", rsp_valid, 0);
    wait_idle();

    // Fill the queue behind a busy controller
    force_busy = 1'b1;
    cyc(2);
    push_req(1'b1, 24'h000010, 16'ha001);
    push_req(1'b1, 24'h000020, 16'ha002);
    push_req(1'b1, 24'h000030, 16'ha003);
    push_req(1'b1, 24'h000040, 16'ha004);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 24'h000050; req_wdata = 16'ha005;
    repeat (3) begin
      cyc(1);
      chk("full_ready", req_ready, 0);
      chk("full_level", q_level, 4);
    end
    force_busy = 1'b0;
    push_req(1'b1, 24'h000050, 16'ha005);
    wait_idle();

    // Second read stalls while the response slot is occupied
    rsp_ready = 1'b0;
    base = issued;
    exp_rsp.push_back(16'h1334);
    exp_rsp.push_back(16'h1034);
    push_req(1'b0, 24'h000100, 16'h0000);
    push_req(1'b0, 24'h000200, 16'h0000);
    n = 0;
    while (!rsp_valid && n < 100) begin cyc(1); n++; end
    cyc(20);
    chk("stall_issued", issued, base + 1);
    chk("stall_level", q_level, 1);
    chk("stall_rsp", {rsp_valid, rsp_data}, {1'b1, 16'h1334});
    rsp_ready = 1'b1;
    wait_idle();
    chk("stall_release_issued", issued, base + 2);

    // Controller never answers: enable dropped after BUSY_WAIT cycles
    never_busy = 1'b1;
    push_req(1'b1, 24'h0000aa, 16'h00aa);
    push_req(1'b1, 24'h0000bb, 16'h00bb);
    wait_en();
    n = 0;
    while ((ctl_wr_en || ctl_rd_en) && n < 100) begin cyc(1); n++; end
    chk("drop_len", n, 15);
    wait_en();
    never_busy = 1'b0;
    wait_idle();
`ifdef SDRAM_HOST_QUEUE_STATS_EN
    chk("stat_drop", stat_drop_cnt, 1);
    chk("stat_wr", stat_wr_cnt, 7);
    chk("stat_rd", stat_rd_cnt, 3);
`endif

    // Reset while waiting on the controller with three requests queued
    busy_len = 20;
    push_req(1'b1, 24'h000600, 16'h0606);
    n = 0;
    while (!ctl_busy && n < 50) begin cyc(1); n++; end
    push_req(1'b1, 24'h000700, 16'h0707);
    push_req(1'b0, 24'h000800, 16'h0000);
    push_req(1'b1, 24'h000900, 16'h0909);
    chk("pre_rst_level", q_level, 3);
    rst = 1'b1;
    cyc(1);
    chk("mid_rst_level", q_level, 0);
    chk("mid_rst_enables", {ctl_wr_en, ctl_rd_en}, 0);
    chk("mid_rst_rsp_valid", rsp_valid, 0);
    chk("mid_rst_ready", req_ready, 1);
`ifdef SDRAM_HOST_QUEUE_STATS_EN
    chk("mid_rst_stats", {stat_wr_cnt, stat_rd_cnt, stat_drop_cnt}, 0);
`endif
    cyc(1);
    rst = 1'b0;
    exp_cmd.delete();
    busy_len = 3;
    cyc(2);
    push_req(1'b1, 24'h000a00, 16'h0a0a);
    chk("post_rst_early", ctl_wr_en, 0);
    cyc(1);
    chk("post_rst_issue", ctl_wr_en, 1);
    wait_idle();

    chk("cmd_queue_drained", exp_cmd.size(), 0);
    chk("rsp_queue_drained", exp_rsp.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
